// File: rtl/vga_capture.sv
// Locks onto an incoming VGA raster, measures its timing and writes the centre
// pixel of every displayed cell back to cell memory as a live/dead bit.
module vga_capture #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned HSIZE       = 800,
    parameter int unsigned VSIZE       = 600,
    parameter logic        HSPP        = 1'b1,
    parameter logic        VSPP        = 1'b1,
    parameter int unsigned P_PARAM_N   = 20,
    parameter int unsigned P_PARAM_M   = 15,
    parameter int unsigned PIX_DLY     = 1,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 data_enable,
    input  logic [7:0]           video_red,
    input  logic [7:0]           video_green,
    input  logic [7:0]           video_blue,
    output logic                 locked,
    output logic                 wr_en,
    output logic [2*WIDTH-1:0]   wr_addr,
    output logic                 wr_live,
    output logic                 frame_done,
    output logic [7:0]           err_count,
    output logic [WIDTH-1:0]     meas_htotal,
    output logic [WIDTH-1:0]     meas_vtotal
);

    localparam int unsigned AW   = 2 * WIDTH;
    localparam int unsigned CELL = HSIZE / P_PARAM_N;
    localparam int unsigned HALF = CELL / 2;

    typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

    state_t state_q, state_d;

    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic hs_prev_q, vs_prev_q, de_prev_q;
    logic [2:0] rgb_msb_q, rgb_msb_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, hline_q, hline_d, vline_q, vline_d;
    logic [WIDTH-1:0] subx_q, subx_d, suby_q, suby_d, cx_q, cx_d, cy_q, cy_d;
    logic [WIDTH-1:0] prev_h_q, prev_h_d, prev_v_q, prev_v_d;
    logic [WIDTH-1:0] meas_htotal_q, meas_htotal_d, meas_vtotal_q, meas_vtotal_d;
    logic line_bad_q, line_bad_d, capture_q, capture_d;
    logic [7:0] good_q, good_d, err_q, err_d;
    logic locked_q, locked_d, frame_done_q, frame_done_d;
    logic wr_en_q, wr_en_d, wr_live_q, wr_live_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;

    logic hs_rise_c, vs_rise_c, de_fall_c, line_bad_now_c, frame_ok_c, first_chk_c, lose_c;
    logic [WIDTH-1:0] y_eff_c;
    logic [7:0] good_inc_c;
    logic smp_c, strb_c;
    logic [AW-1:0] smp_addr_c, strb_addr_c;
    logic rgb_unused_c;

    assign rgb_unused_c = ^{video_red[6:0], video_green[6:0], video_blue[6:0]};

    // Datapath: input capture, raster counters, timing measurement, cell position
    always_comb begin
        hs_d      = (hsync == HSPP);
        vs_d      = (vsync == VSPP);
        de_d      = data_enable;
        rgb_msb_d = {video_red[7], video_green[7], video_blue[7]};

        hs_rise_c      = hs_q & ~hs_prev_q;
        vs_rise_c      = vs_q & ~vs_prev_q;
        de_fall_c      = de_prev_q & ~de_q;
        line_bad_now_c = de_fall_c && (x_q != WIDTH'(HSIZE));
        y_eff_c        = de_fall_c ? y_q + WIDTH'(1) : y_q;

        x_d = x_q;             y_d = vs_rise_c ? '0 : y_eff_c;
        hline_d = hline_q + WIDTH'(1);
        vline_d = vline_q;
        subx_d = subx_q;       suby_d = suby_q;
        cx_d = cx_q;           cy_d = cy_q;
        prev_h_d = prev_h_q;   prev_v_d = prev_v_q;
        meas_htotal_d = meas_htotal_q;
        meas_vtotal_d = meas_vtotal_q;
        line_bad_d = vs_rise_c ? 1'b0 : (line_bad_q | line_bad_now_c);

        if (de_fall_c)  x_d = '0;
        else if (de_q)  x_d = x_q + WIDTH'(1);

        if (hs_rise_c) begin
            meas_htotal_d = hline_q + WIDTH'(1);
            hline_d       = '0;
        end

        if (vs_rise_c) begin
            meas_vtotal_d = vline_q;
            prev_h_d      = meas_htotal_q;
            prev_v_d      = vline_q;
            vline_d       = hs_rise_c ? WIDTH'(1) : '0;
        end else if (hs_rise_c) begin
            vline_d = vline_q + WIDTH'(1);
        end

        if (de_fall_c) begin
            subx_d = '0;
            cx_d   = '0;
            if (suby_q == WIDTH'(CELL - 1)) begin
                suby_d = '0;
                cy_d   = cy_q + WIDTH'(1);
            end else begin
                suby_d = suby_q + WIDTH'(1);
            end
        end else if (de_q) begin
            if (subx_q == WIDTH'(CELL - 1)) begin
                subx_d = '0;
                cx_d   = cx_q + WIDTH'(1);
            end else begin
                subx_d = subx_q + WIDTH'(1);
            end
        end
        if (vs_rise_c) begin
            suby_d = '0;
            cy_d   = '0;
        end

        // The first frame after SEARCH has no complete predecessor to compare timing against
        first_chk_c = (state_q == S_CHECK) && (good_q == 8'd0);
        frame_ok_c  = (y_eff_c == WIDTH'(VSIZE)) && !(line_bad_q | line_bad_now_c) &&
                      (first_chk_c || ((meas_htotal_q == prev_h_q) && (vline_q == prev_v_q)));

        smp_c      = capture_q && de_q && (subx_q == WIDTH'(HALF)) &&
                     (suby_q == WIDTH'(HALF)) && (cy_q < WIDTH'(P_PARAM_M));
        smp_addr_c = AW'(cx_q) * AW'(P_PARAM_N) + AW'(cy_q);

        wr_en_d   = strb_c;
        wr_addr_d = strb_c ? strb_addr_c : wr_addr_q;
        wr_live_d = strb_c ? &rgb_msb_q : wr_live_q;
    end

    // Align the sample strobe with RGB, which lags data_enable by PIX_DLY cycles
    if (PIX_DLY == 0) begin : g_nodly
        assign strb_c      = smp_c;
        assign strb_addr_c = smp_addr_c;
    end else begin : g_dly
        logic          dv_q [PIX_DLY];
        logic          dv_d [PIX_DLY];
        logic [AW-1:0] da_q [PIX_DLY];
        logic [AW-1:0] da_d [PIX_DLY];

        always_comb begin
            dv_d[0] = smp_c;
            da_d[0] = smp_addr_c;
            for (int i = 1; i < int'(PIX_DLY); i++) begin
                dv_d[i] = dv_q[i-1];
                da_d[i] = da_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            for (int i = 0; i < int'(PIX_DLY); i++) begin
                dv_q[i] <= rst ? 1'b0 : dv_d[i];
                da_q[i] <= rst ? '0 : da_d[i];
            end
        end

        assign strb_c      = dv_q[PIX_DLY-1];
        assign strb_addr_c = da_q[PIX_DLY-1];
    end

    // Lock FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_SEARCH;
        else     state_q <= state_d;
    end

    // Lock FSM: next state
    always_comb begin
        state_d    = state_q;
        good_inc_c = good_q + 8'd1;
        case (state_q)
            S_SEARCH: if (vs_rise_c) state_d = S_CHECK;
            S_CHECK: begin
                if (vs_rise_c) begin
                    if (!frame_ok_c)                        state_d = S_SEARCH;
                    else if (good_inc_c == 8'(LOCK_FRAMES)) state_d = S_LOCKED;
                end
            end
            S_LOCKED: if (line_bad_now_c || (vs_rise_c && !frame_ok_c)) state_d = S_SEARCH;
            default: state_d = S_SEARCH;
        endcase
    end

    // Lock FSM: outputs, good-frame count, error count and capture window
    always_comb begin
        good_d       = good_q;
        err_d        = err_q;
        capture_d    = capture_q;
        frame_done_d = vs_rise_c && capture_q;
        locked_d     = (state_d == S_LOCKED);
        lose_c       = (state_q == S_LOCKED) && (state_d != S_LOCKED);

        if (state_d != S_CHECK)                      good_d = 8'd0;
        else if (state_q == S_CHECK && vs_rise_c)    good_d = good_inc_c;

        if (lose_c && err_q != 8'hFF) err_d = err_q + 8'd1;

        if (lose_c)          capture_d = 1'b0;
        else if (vs_rise_c)  capture_d = (state_q == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0;
            hs_prev_q <= 1'b0; vs_prev_q <= 1'b0; de_prev_q <= 1'b0;
            rgb_msb_q <= '0;
            x_q <= '0; y_q <= '0; hline_q <= '0; vline_q <= '0;
            subx_q <= '0; suby_q <= '0; cx_q <= '0; cy_q <= '0;
            prev_h_q <= '0; prev_v_q <= '0;
            meas_htotal_q <= '0; meas_vtotal_q <= '0;
            line_bad_q <= 1'b0; capture_q <= 1'b0;
            good_q <= 8'd0; err_q <= 8'd0;
            locked_q <= 1'b0; frame_done_q <= 1'b0;
            wr_en_q <= 1'b0; wr_addr_q <= '0; wr_live_q <= 1'b0;
        end else begin
            hs_q <= hs_d; vs_q <= vs_d; de_q <= de_d;
            hs_prev_q <= hs_q; vs_prev_q <= vs_q; de_prev_q <= de_q;
            rgb_msb_q <= rgb_msb_d;
            x_q <= x_d; y_q <= y_d; hline_q <= hline_d; vline_q <= vline_d;
            subx_q <= subx_d; suby_q <= suby_d; cx_q <= cx_d; cy_q <= cy_d;
            prev_h_q <= prev_h_d; prev_v_q <= prev_v_d;
            meas_htotal_q <= meas_htotal_d; meas_vtotal_q <= meas_vtotal_d;
            line_bad_q <= line_bad_d; capture_q <= capture_d;
            good_q <= good_d; err_q <= err_d;
            locked_q <= locked_d; frame_done_q <= frame_done_d;
            wr_en_q <= wr_en_d; wr_addr_q <= wr_addr_d; wr_live_q <= wr_live_d;
        end
    end

    assign locked      = locked_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_live     = wr_live_q;
    assign frame_done  = frame_done_q;
    assign err_count   = err_q;
    assign meas_htotal = meas_htotal_q;
    assign meas_vtotal = meas_vtotal_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: a 24x20 raster with a 4x4 checkerboard, driven
// into a positive-sync and an inverted-sync instance.
`timescale 1ns/1ps
module tb_vga_capture;

    localparam int HS = 16, HFP = 18, HSP = 20, HMAX = 24;
    localparam int VS = 16, VFP = 17, VSP = 18, VMAX = 20;

    typedef struct packed {
        logic [23:0] addr;
        logic        live;
    } wr_t;

    logic clk = 1'b0;
    logic rst, hsync, vsync, de;
    logic [7:0] red, green, blue;
    logic hsync_n, vsync_n;

    logic        locked, wr_en, wr_live, frame_done;
    logic [23:0] wr_addr;
    logic [7:0]  err_count;
    logic [11:0] meas_htotal, meas_vtotal;

    logic        locked_n, wr_en_n, wr_live_n, frame_done_n;
    logic [23:0] wr_addr_n;
    logic [7:0]  err_count_n;
    logic [11:0] meas_htotal_n, meas_vtotal_n;

    int vectors = 0, miscompares = 0;
    int wr_cnt = 0, fd_cnt = 0, wr_cnt_n = 0, fd_cnt_n = 0;
    wr_t exp_q[$];

    assign hsync_n = ~hsync;
    assign vsync_n = ~vsync;

    always #5 clk = ~clk;

    vga_capture #(.WIDTH(12), .HSIZE(16), .VSIZE(16), .HSPP(1'b1), .VSPP(1'b1),
                  .P_PARAM_N(4), .P_PARAM_M(4), .PIX_DLY(1), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .data_enable(de),
        .video_red(red), .video_green(green), .video_blue(blue),
        .locked(locked), .wr_en(wr_en), .wr_addr(wr_addr), .wr_live(wr_live),
        .frame_done(frame_done), .err_count(err_count),
        .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal));

    vga_capture #(.WIDTH(12), .HSIZE(16), .VSIZE(16), .HSPP(1'b0), .VSPP(1'b0),
                  .P_PARAM_N(4), .P_PARAM_M(4), .PIX_DLY(1), .LOCK_FRAMES(2)) dut_n (
        .clk(clk), .rst(rst), .hsync(hsync_n), .vsync(vsync_n), .data_enable(de),
        .video_red(red), .video_green(green), .video_blue(blue),
        .locked(locked_n), .wr_en(wr_en_n), .wr_addr(wr_addr_n), .wr_live(wr_live_n),
        .frame_done(frame_done_n), .err_count(err_count_n),
        .meas_htotal(meas_htotal_n), .meas_vtotal(meas_vtotal_n));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Live cells are checkerboard; only the centre pixel carries the cell's true colour
    function automatic logic [23:0] pix(input int px, input int py);
        bit live = (((px / 4) + (py / 4)) % 2) == 0;
        bit ctr  = ((px % 4) == 2) && ((py % 4) == 2);
        if (ctr) return live ? 24'h808080 : 24'h7FFFFF;
        return live ? 24'h7FFFFF : 24'hFFFFFF;
    endfunction

    // Monitor: pop the scoreboard on every write, count strobes from both instances
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin : pop
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h live %0b, expected no write", wr_addr, wr_live);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_live", 32'(wr_live), 32'(e.live));
            end
        end
        if (frame_done === 1'b1)   fd_cnt++;
        if (wr_en_n === 1'b1)      wr_cnt_n++;
        if (frame_done_n === 1'b1) fd_cnt_n++;
    end

    task automatic drive_frame(input int max_push, input int short_line,
                               input int rst_line, input int rst_hc);
        int  pushed = 0;
        wr_t e;
        for (int vc = 0; vc < VMAX; vc++) begin
            for (int hc = 0; hc < HMAX; hc++) begin
                @(posedge clk);
                #1;
                hsync = (hc >= HFP) && (hc < HSP);
                vsync = (vc >= VFP) && (vc < VSP);
                de    = (vc < VS) && (hc < HS) && !((vc == short_line) && (hc == HS - 1));
                if (vc < VS && hc >= 1 && hc <= HS) {red, green, blue} = pix(hc - 1, vc);
                else                                {red, green, blue} = 24'h0;
                if (de && (hc % 4) == 2 && (vc % 4) == 2 && pushed < max_push) begin
                    e.addr = 24'((hc / 4) * 4 + (vc / 4));
                    e.live = (((hc / 4) + (vc / 4)) % 2) == 0;
                    exp_q.push_back(e);
                    pushed++;
                end
                if (vc == rst_line && hc == rst_hc) begin
                    rst = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        {red, green, blue} = 24'h0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_locked"},      32'(locked),      32'h0);
        check({tag, "_wr_en"},       32'(wr_en),       32'h0);
        check({tag, "_wr_addr"},     32'(wr_addr),     32'h0);
        check({tag, "_wr_live"},     32'(wr_live),     32'h0);
        check({tag, "_frame_done"},  32'(frame_done),  32'h0);
        check({tag, "_err_count"},   32'(err_count),   32'h0);
        check({tag, "_meas_htotal"}, 32'(meas_htotal), 32'h0);
        check({tag, "_meas_vtotal"}, 32'(meas_vtotal), 32'h0);
        check({tag, "_n_locked"},    32'(locked_n),    32'h0);
        check({tag, "_n_meas_h"},    32'(meas_htotal_n), 32'h0);
    endtask

    // Clean stream from reset: lock after boundary 3, capture frame 4 (16 writes)
    task automatic lock_and_capture(input int wr_base, input int fd_base);
        for (int f = 0; f < 4; f++) begin
            drive_frame(0, -1, -1, -1);
            if (f == 1) check("locked_after_b2", 32'(locked), 32'h0);
            if (f == 2) begin
                check("locked_after_b3",   32'(locked),   32'h1);
                check("n_locked_after_b3", 32'(locked_n), 32'h1);
            end
        end
        check("no_write_before_capture", 32'(wr_cnt), 32'(wr_base));
        drive_frame(16, -1, -1, -1);
        check("capture_writes",    32'(wr_cnt),        32'(wr_base + 16));
        check("scoreboard_empty",  32'(exp_q.size()),  32'h0);
        check("frame_done_count",  32'(fd_cnt),        32'(fd_base + 1));
        check("meas_htotal",       32'(meas_htotal),   32'd24);
        check("meas_vtotal",       32'(meas_vtotal),   32'd20);
        check("n_capture_writes",  32'(wr_cnt_n),      32'(wr_base + 16));
        check("n_frame_done",      32'(fd_cnt_n),      32'(fd_base + 1));
        check("n_meas_htotal",     32'(meas_htotal_n), 32'd24);
        check("n_meas_vtotal",     32'(meas_vtotal_n), 32'd20);
        check("err_clean",         32'(err_count),     32'h0);
    endtask

    initial begin
        rst = 1'b1;
        hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        {red, green, blue} = 24'h0;
        do_reset(100);
        check_idle("por");
        rst = 1'b0;

        lock_and_capture(0, 0);

        // Line 5 of frame 5 loses one pixel: only row 0 is written before lock drops
        drive_frame(4, 5, -1, -1);
        check("short_locked",   32'(locked),       32'h0);
        check("short_err",      32'(err_count),    32'h1);
        check("short_n_err",    32'(err_count_n),  32'h1);
        check("short_writes",   32'(wr_cnt),       32'd20);
        check("short_sb_empty", 32'(exp_q.size()), 32'h0);
        check("short_fd",       32'(fd_cnt),       32'd1);

        drive_frame(0, -1, -1, -1);
        check("relock_b7_locked", 32'(locked), 32'h0);
        drive_frame(0, -1, -1, -1);
        check("relock_b8_locked", 32'(locked), 32'h1);
        check("relock_err_held",  32'(err_count), 32'h1);
        drive_frame(0, -1, -1, -1);
        check("relock_no_writes", 32'(wr_cnt), 32'd20);

        // Reset asserted mid-capture right after the fifth write's strobe has issued
        drive_frame(5, -1, 6, 7);
        do_reset(10);
        check_idle("midrst");
        check("midrst_writes",   32'(wr_cnt),       32'd25);
        check("midrst_sb_empty", 32'(exp_q.size()), 32'h0);
        check("midrst_fd",       32'(fd_cnt),       32'd1);
        rst = 1'b0;

        lock_and_capture(25, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
